self_trigger_fifo: RTL

Buffers self-trigger events for readout. Sits directly downstream of the channel self-trigger stage in the 400 MHz ADC clock domain: it detects each trigger pulse, captures the 42-bit timestamp at the rising edge, measures the pulse width in clock ticks, and queues `{width, timestamp}` records in a small FIFO. The readout logic drains the FIFO with a simple read-enable handshake.

---
 rtl/self_trigger_fifo.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/self_trigger_fifo.sv
// Self-trigger event capture: measures each trigger pulse and queues {width, timestamp} records for readout.
// Optional width counter: define SELF_TRIG_FIFO_WIDTH_EN; when undefined the width field reads as zero.
module self_trigger_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic [41:0]       timestamp,
    input  logic              enable,
    input  logic              clear,
    input  logic              rd_en,
    output logic [49:0]       dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_MEASURE = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] C_DEPTH = DEPTH[ADDR_W:0];

    // enable arrives from another domain; two flops before anything looks at it
    (* ASYNC_REG = "TRUE" *) logic r_en_meta;
    (* ASYNC_REG = "TRUE" *) logic r_en_sync;

    logic              r_trig_d;
    state_t            r_state;
    logic [41:0]       r_ts;
    logic [49:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [49:0]       r_dout;
    logic              r_dout_valid;
    logic              r_overflow;
    logic [15:0]       r_drop_count;

    logic              w_rise;
    logic              w_fall;
    logic              w_capture;
    logic              w_commit;
    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_drop;
    logic [7:0]        w_width;
    logic [49:0]       w_record;

    assign w_rise    = trigger & ~r_trig_d;
    assign w_fall    = ~trigger & r_trig_d;
    // A rise is captured from ARMED, and also from COMMIT so back-to-back pulses are not lost
    assign w_capture = r_en_sync & w_rise & ((r_state == S_ARMED) | (r_state == S_COMMIT));
    assign w_commit  = (r_state == S_COMMIT);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_DEPTH);
    assign w_rd_acc  = rd_en & ~w_empty;
    assign w_wr_acc  = w_commit & (~w_full | w_rd_acc);
    assign w_drop    = w_commit & ~w_wr_acc;
    assign w_record  = {w_width, r_ts};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_en_meta <= 1'b0;
            r_en_sync <= 1'b0;
            r_trig_d  <= 1'b0;
        end else begin
            r_en_meta <= enable;
            r_en_sync <= r_en_meta;
            r_trig_d  <= trigger;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= S_IDLE;
            r_ts    <= '0;
        end else begin
            if (w_capture) begin
                r_ts <= timestamp;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_en_sync) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (!r_en_sync)     r_state <= S_IDLE;
                    else if (w_rise)    r_state <= S_MEASURE;
                end
                S_MEASURE: begin
                    if (!r_en_sync)     r_state <= S_IDLE;
                    else if (w_fall)    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (!r_en_sync)     r_state <= S_IDLE;
                    else if (w_rise)    r_state <= S_MEASURE;
                    else                r_state <= S_ARMED;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SELF_TRIG_FIFO_WIDTH_EN
    logic [7:0] r_width;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_width <= '0;
        end else if (w_capture) begin
            r_width <= 8'd1;
        end else if ((r_state == S_MEASURE) && trigger && (r_width != 8'hFF)) begin
            r_width <= r_width + 8'd1;
        end
    end

    assign w_width = r_width;
`else
    assign w_width = 8'd0;
`endif

    // NOTE: storage array has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && !clear && w_wr_acc) begin
            r_mem[r_wr_ptr] <= w_record;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_dout_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
